// File: rtl/fetch_unit.sv
// Instruction prefetch front end: fetches code bytes one at a time over a req/ack port
// into a small byte queue and presents the four bytes at eip to decode.
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                QDEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_EIP = '0
) (
    input  logic              clk2,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [31:0]       ope,
    output logic              ope_valid,
    input  logic              advance,
    input  logic [3:0]        num_of_ope,
    output logic              adv_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] eip
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int NW = (CW > 4) ? CW : 4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t            state;
    logic [7:0]        queue [QDEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [NW-1:0]     need;
    logic [NW-1:0]     have;
    logic              push;
    logic              pop;
    logic              room;

    assign need      = NW'(num_of_ope);
    assign have      = NW'(count);
    assign adv_ready = (need <= have);
    assign pop       = advance && !jump && adv_ready;
    // Only S_REQ keeps fetched data; an ack arriving with a jump belongs to the old stream.
    assign push      = (state == S_REQ) && mem_ack && !jump;

    always_comb begin
        count_next = '0;
        if (!jump)
            count_next = count + CW'(push) - (pop ? CW'(num_of_ope) : '0);
    end

    assign room      = (count_next < CW'(QDEPTH));
    assign ope_valid = (count >= CW'(4));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [PW-1:0] idx;
            assign idx = rd_ptr + PW'(gi);
            assign ope[31-8*gi -: 8] = (count > CW'(gi)) ? queue[idx] : 8'h00;
        end
    endgenerate

    // Queue storage needs no reset: lanes beyond count are masked to zero.
    always_ff @(posedge clk2) begin
        if (push)
            queue[wr_ptr] <= mem_data;
    end

    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_EIP;
            eip        <= RESET_EIP;
            fetch_addr <= RESET_EIP;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            count <= count_next;

            if (jump) begin
                eip        <= jump_target;
                fetch_addr <= jump_target;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (pop) begin
                    eip    <= eip + ADDR_W'(num_of_ope);
                    rd_ptr <= rd_ptr + PW'(num_of_ope);
                end
                if (push) begin
                    wr_ptr     <= wr_ptr + PW'(1);
                    fetch_addr <= fetch_addr + ADDR_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (!jump && room) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (jump || !room) begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= fetch_addr + ADDR_W'(1);
                        end
                    end else if (jump) begin
                        // The bus cannot abort a request; finish it and throw the byte away.
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance on a wait-state memory model and an
// 8-bit instance on a zero-wait memory for address wrap and async reset.
module tb_fetch_unit;
    logic clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    int tests  = 0;
    int errors = 0;

    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [31:0] ope;
    logic        ope_valid;
    logic        advance;
    logic [3:0]  num_of_ope;
    logic        adv_ready;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] eip;

    logic        b_reset;
    logic        b_mem_req;
    logic [7:0]  b_mem_addr;
    logic        b_mem_ack;
    logic [7:0]  b_mem_data;
    logic [31:0] b_ope;
    logic        b_ope_valid;
    logic        b_advance;
    logic [3:0]  b_num;
    logic        b_adv_ready;
    logic        b_jump;
    logic [7:0]  b_jump_target;
    logic [7:0]  b_eip;

    fetch_unit dut (
        .clk2(clk2), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .ope(ope), .ope_valid(ope_valid),
        .advance(advance), .num_of_ope(num_of_ope), .adv_ready(adv_ready),
        .jump(jump), .jump_target(jump_target), .eip(eip)
    );

    fetch_unit #(.ADDR_W(8)) dut_b (
        .clk2(clk2), .reset(b_reset), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_ack(b_mem_ack), .mem_data(b_mem_data), .ope(b_ope), .ope_valid(b_ope_valid),
        .advance(b_advance), .num_of_ope(b_num), .adv_ready(b_adv_ready),
        .jump(b_jump), .jump_target(b_jump_target), .eip(b_eip)
    );

    // Zero-wait memory for the narrow instance: byte at address a is a+1.
    assign b_mem_ack  = b_mem_req;
    assign b_mem_data = b_mem_addr + 8'h01;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h55;
            32'd1:   return 8'h89;
            32'd2:   return 8'he5;
            32'd3:   return 8'hb8;
            32'd4:   return 8'h01;
            32'd5:   return 8'h00;
            32'd6:   return 8'h00;
            32'd7:   return 8'h00;
            default: return a[7:0] + 8'h10;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // Memory responder: ack after wait_target idle cycles, one request at a time.
    int wait_target = 0;
    int wcnt        = 0;
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge clk2);
            if (mem_ack) wcnt = 0;
            if (mem_req) begin
                if (wcnt >= wait_target) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_byte(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    int          ack_count = 0;
    logic [31:0] last_ack_addr = '0;
    always @(posedge clk2) begin
        if (!reset && mem_req && mem_ack) begin
            ack_count++;
            last_ack_addr = mem_addr;
        end
    end

    task automatic do_reset();
        @(negedge clk2);
        reset      = 1'b1;
        advance    = 1'b0;
        jump       = 1'b0;
        num_of_ope = 4'd0;
        repeat (2) @(negedge clk2);
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1; advance = 1'b0; num_of_ope = 4'd0; jump = 1'b0; jump_target = '0;
        b_reset = 1'b1; b_advance = 1'b0; b_num = 4'd0; b_jump = 1'b0; b_jump_target = '0;
        repeat (2) @(negedge clk2);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_eip",       eip,       32'h0);
        check("rst_ope",       ope,       32'h0);
        check("rst_ope_valid", ope_valid, 1'b0);

        // First fill from address 0 with zero-wait memory
        reset = 1'b0;
        @(negedge clk2);
        check("t1_first_req",  mem_req,  1'b1);
        check("t1_first_addr", mem_addr, 32'h0);
        repeat (3) @(negedge clk2);
        check("t1_three_valid", ope_valid, 1'b0);
        check("t1_three_ope",   ope,       32'h5589e500);
        @(negedge clk2);
        check("t1_ope",   ope,       32'h5589e5b8);
        check("t1_valid", ope_valid, 1'b1);
        check("t1_eip",   eip,       32'h0);

        // Advance by one while a byte is pushed in the same cycle
        advance = 1'b1; num_of_ope = 4'd1;
        @(negedge clk2);
        advance = 1'b0;
        check("t2_eip",   eip,       32'h1);
        check("t2_ope",   ope,       32'h89e5b801);
        check("t2_valid", ope_valid, 1'b1);

        // Fill to full depth, then release room with a 5-byte advance
        do_reset();
        base = ack_count;
        repeat (15) @(negedge clk2);
        check("t3_ack_count", ack_count - base, 8);
        check("t3_last_addr", last_ack_addr,    32'h7);
        check("t3_full_req",  mem_req,          1'b0);
        check("t3_full_ope",  ope,              32'h5589e5b8);
        advance = 1'b1; num_of_ope = 4'd5;
        @(negedge clk2);
        advance = 1'b0;
        check("t3_eip",       eip,       32'h5);
        check("t3_req",       mem_req,   1'b1);
        check("t3_addr",      mem_addr,  32'h8);
        check("t3_valid",     ope_valid, 1'b0);

        // Jump while the request to address 6 is stalled
        wait_target = 3;
        do_reset();
        for (int k = 0; k < 200 && !(mem_req && mem_addr == 32'h6); k++) @(negedge clk2);
        check("t4_reach_addr6", mem_req && mem_addr == 32'h6, 1'b1);
        jump = 1'b1; jump_target = 32'h100;
        @(negedge clk2);
        jump = 1'b0;
        check("t4_eip",        eip,       32'h100);
        check("t4_valid",      ope_valid, 1'b0);
        check("t4_drain_req",  mem_req,   1'b1);
        check("t4_drain_addr", mem_addr,  32'h6);
        @(negedge clk2);
        check("t4_hold_req",   mem_req,   1'b1);
        check("t4_hold_addr",  mem_addr,  32'h6);
        for (int k = 0; k < 200 && !ope_valid; k++) @(negedge clk2);
        check("t4_refill_valid", ope_valid, 1'b1);
        check("t4_refill_ope",   ope,       32'h10111213);
        check("t4_refill_eip",   eip,       32'h100);

        // Advance longer than the queue contents must wait for one more byte
        advance = 1'b1; num_of_ope = 4'd5;
        #1;
        check("t5_not_ready", adv_ready, 1'b0);
        @(negedge clk2);
        check("t5_eip_hold", eip, 32'h100);
        check("t5_ope_hold", ope, 32'h10111213);
        for (int k = 0; k < 40 && eip == 32'h100; k++) @(negedge clk2);
        advance = 1'b0;
        check("t5_eip", eip, 32'h105);

        // Narrow instance: eip wraps modulo 256, async reset mid-request
        @(negedge clk2);
        b_reset = 1'b0;
        repeat (3) @(negedge clk2);
        b_jump = 1'b1; b_jump_target = 8'hFE;
        @(negedge clk2);
        b_jump = 1'b0;
        for (int k = 0; k < 40 && !b_ope_valid; k++) @(negedge clk2);
        check("t6_fill_valid", b_ope_valid, 1'b1);
        check("t6_fill_ope",   b_ope,       32'hFF000102);
        b_advance = 1'b1; b_num = 4'd3;
        @(negedge clk2);
        b_advance = 1'b0;
        check("t6_wrap_eip", b_eip, 8'h01);
        check("t6_wrap_ope", b_ope, 32'h02030000);
        #2;
        b_reset = 1'b1;
        #1;
        check("t6_async_req",   b_mem_req,   1'b0);
        check("t6_async_eip",   b_eip,       8'h00);
        check("t6_async_valid", b_ope_valid, 1'b0);
        #1;
        b_reset = 1'b0;
        @(negedge clk2);
        check("t6_restart_req",  b_mem_req,  1'b1);
        check("t6_restart_addr", b_mem_addr, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
